// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one-outstanding imem requests, holds IF/ID plus a 1-entry skid.
// Latency: request 1 cycle after ISSUE, IF/ID loads on the response edge; redirects squash in-flight data.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'h0000_0001,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  JMPSel,
  input  logic [31:0] Address,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  logic        iv_nxt;
  logic [31:0] instr_nxt, pco_nxt;
  logic        skid_vld, skid_vld_nxt;
  logic [31:0] skid_instr, skid_instr_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic        squash, squash_nxt;

  logic consume, jump, redirect;

  assign consume  = instr_valid && !stall;
  assign jump     = consume && (JMPSel == 2'b01);
  assign redirect = branch_taken || jump;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_nxt        = 1'b0;
    addr_nxt       = imem_addr;
    iv_nxt         = instr_valid;
    instr_nxt      = instruction;
    pco_nxt        = pc_out;
    skid_vld_nxt   = skid_vld;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;
    squash_nxt     = squash;

    if (consume) begin
      iv_nxt    = 1'b0;
      instr_nxt = NOP_INSTR;
    end

    if (redirect) begin
      pc_nxt       = branch_taken ? branch_target : Address;
      iv_nxt       = 1'b0;
      instr_nxt    = NOP_INSTR;
      skid_vld_nxt = 1'b0;
      // A response still in flight belongs to the old path; mark it for dropping.
      if (state == WAIT && !imem_rvalid) begin
        squash_nxt = 1'b1;
      end else begin
        squash_nxt = 1'b0;
        state_nxt  = ISSUE;
      end
    end else begin
      case (state)
        ISSUE: begin
          req_nxt   = 1'b1;
          addr_nxt  = pc;
          state_nxt = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_nxt = ISSUE;
            if (squash) begin
              squash_nxt = 1'b0;
            end else if (!instr_valid || consume) begin
              iv_nxt    = 1'b1;
              instr_nxt = imem_rdata;
              pco_nxt   = pc;
              pc_nxt    = pc + PC_STEP;
            end else begin
              skid_vld_nxt   = 1'b1;
              skid_instr_nxt = imem_rdata;
              skid_pc_nxt    = pc;
              pc_nxt         = pc + PC_STEP;
              state_nxt      = HOLD;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            iv_nxt       = 1'b1;
            instr_nxt    = skid_instr;
            pco_nxt      = skid_pc;
            skid_vld_nxt = 1'b0;
            state_nxt    = ISSUE;
          end
        end
        default: state_nxt = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      pc_out      <= 32'h0;
      skid_vld    <= 1'b0;
      skid_instr  <= 32'h0;
      skid_pc     <= 32'h0;
      squash      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      imem_req    <= req_nxt;
      imem_addr   <= addr_nxt;
      instr_valid <= iv_nxt;
      instruction <= instr_nxt;
      pc_out      <= pco_nxt;
      skid_vld    <= skid_vld_nxt;
      skid_instr  <= skid_instr_nxt;
      skid_pc     <= skid_pc_nxt;
      squash      <= squash_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table for sequential fetch and stall/skid, then directed
// sequences for jump, branch-under-stall, memory latency 3 and reset during an outstanding fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  JMPSel;
  logic [31:0] Address;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .JMPSel(JMPSel), .Address(Address),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instruction(instruction), .pc_out(pc_out),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int stale_hits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: response arrives mem_lat cycles after the request cycle; data = ~addr.
  bit          pend = 1'b0;
  int          cd = 0;
  logic [31:0] paddr = 32'h0;
  int          mem_lat = 1;
  bit          mem_auto = 1'b1;
  bit          inject = 1'b0;

  initial forever begin
    @(negedge clk);
    if (mem_auto && imem_req) begin
      check("one_outstanding", {31'b0, pend}, 32'd0);
      pend  = 1'b1;
      cd    = mem_lat;
      paddr = imem_addr;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    imem_rvalid = 1'b0;
    if (inject) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (pend) begin
      cd--;
      if (cd == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~paddr;
        pend        = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task automatic scan(input logic [31:0] bad);
    if ((imem_req && imem_addr == bad) ||
        (instr_valid && (pc_out == bad || instruction == 32'hDEAD_BEEF)))
      stale_hits++;
  endtask

  task automatic wait_req(input string name, input logic [31:0] bad, input int bound,
                          output logic [31:0] a, output int t);
    bit found = 1'b0;
    a = 32'h0;
    t = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      scan(bad);
      if (imem_req) begin
        found = 1'b1;
        a = imem_addr;
        t = cyc;
      end
    end
    check({name, "_req_seen"}, {31'b0, found}, 32'd1);
  endtask

  task automatic wait_vld(input string name, input logic [31:0] bad, input int bound,
                          output logic [31:0] p, output logic [31:0] d);
    bit found = 1'b0;
    p = 32'h0;
    d = 32'h0;
    for (int i = 0; i < bound && !found; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      scan(bad);
      if (instr_valid) begin
        found = 1'b1;
        p = pc_out;
        d = instruction;
      end
    end
    check({name, "_vld_seen"}, {31'b0, found}, 32'd1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_req"},   {31'b0, imem_req},    32'd0);
    check({name, "_addr"},  imem_addr,            32'd0);
    check({name, "_vld"},   {31'b0, instr_valid}, 32'd0);
    check({name, "_instr"}, instruction,          32'd0);
    check({name, "_pc"},    pc_out,               32'd0);
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [31:0] a, p, d;
    int t1, t2, t3;

    // Cycle k after reset release: {stall, exp req, exp addr, exp valid, exp pc}.
    vecs[0]  = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'd1, 1'b0, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'd1, 1'b1, 32'd1};
    vecs[6]  = '{1'b0, 1'b1, 32'd2, 1'b0, 32'd0};
    vecs[7]  = '{1'b0, 1'b0, 32'd2, 1'b0, 32'd0};
    vecs[8]  = '{1'b1, 1'b0, 32'd2, 1'b1, 32'd2};
    vecs[9]  = '{1'b1, 1'b1, 32'd3, 1'b1, 32'd2};
    vecs[10] = '{1'b1, 1'b0, 32'd3, 1'b1, 32'd2};
    vecs[11] = '{1'b1, 1'b0, 32'd3, 1'b1, 32'd2};
    vecs[12] = '{1'b1, 1'b0, 32'd3, 1'b1, 32'd2};
    vecs[13] = '{1'b1, 1'b0, 32'd3, 1'b1, 32'd2};
    vecs[14] = '{1'b0, 1'b0, 32'd3, 1'b1, 32'd2};
    vecs[15] = '{1'b0, 1'b0, 32'd3, 1'b1, 32'd3};
    vecs[16] = '{1'b0, 1'b1, 32'd4, 1'b0, 32'd0};
    vecs[17] = '{1'b0, 1'b0, 32'd4, 1'b0, 32'd0};
    vecs[18] = '{1'b1, 1'b0, 32'd4, 1'b1, 32'd4};

    rst = 1'b1; stall = 1'b0; JMPSel = 2'b00; Address = 32'h0;
    branch_taken = 1'b0; branch_target = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential fetch with 1-cycle memory, then a 6-cycle stall filling the skid.
    for (int k = 0; k < 19; k++) begin
      @(posedge clk); #1;
      stall = vecs[k].stall;
      @(negedge clk);
      check($sformatf("seq%0d_req", k), {31'b0, imem_req}, {31'b0, vecs[k].req});
      if (vecs[k].req) check($sformatf("seq%0d_addr", k), imem_addr, vecs[k].addr);
      check($sformatf("seq%0d_vld", k), {31'b0, instr_valid}, {31'b0, vecs[k].vld});
      if (vecs[k].vld) begin
        check($sformatf("seq%0d_pc", k), pc_out, vecs[k].pc);
        check($sformatf("seq%0d_instr", k), instruction, ~vecs[k].pc);
      end else begin
        check($sformatf("seq%0d_nop", k), instruction, 32'h0);
      end
    end

    // Jump to 0x40 consumed while the fetch of pc 5 is outstanding.
    @(posedge clk); #1;
    stall = 1'b0; JMPSel = 2'b01; Address = 32'h40;
    @(negedge clk);
    check("jmp_inflight_addr", imem_req ? imem_addr : 32'hFFFF_FFFF, 32'd5);
    @(posedge clk); #1;
    JMPSel = 2'b00; Address = 32'h0;
    @(negedge clk);
    check("jmp_flush_vld", {31'b0, instr_valid}, 32'd0);
    stale_hits = 0;
    wait_req("jmp", 32'd5, 10, a, t1);
    check("jmp_target_addr", a, 32'h40);
    stall = 1'b1;
    wait_vld("jmp", 32'd5, 10, p, d);
    check("jmp_pc", p, 32'h40);
    check("jmp_instr", d, ~32'h40);
    check("jmp_no_pc5", stale_hits, 32'd0);

    // Branch under stall beats a simultaneous jump request.
    branch_taken = 1'b1; branch_target = 32'h100; JMPSel = 2'b01; Address = 32'h40;
    @(posedge clk); #1;
    branch_taken = 1'b0; branch_target = 32'h0; JMPSel = 2'b00; Address = 32'h0;
    @(negedge clk);
    check("br_flush_vld", {31'b0, instr_valid}, 32'd0);
    check("br_flush_nop", instruction, 32'h0);
    stall = 1'b0;
    stale_hits = 0;
    wait_req("br", 32'h40, 10, a, t1);
    check("br_target_addr", a, 32'h100);
    wait_vld("br", 32'h40, 10, p, d);
    check("br_pc", p, 32'h100);
    check("br_instr", d, ~32'h100);
    check("br_no_0x40", stale_hits, 32'd0);

    // Memory latency 3: request pulses 5 cycles apart.
    mem_lat = 3;
    wait_req("lat3a", 32'hFFFF_FFFF, 12, a, t1);
    check("lat3_addr0", a, 32'h101);
    wait_req("lat3b", 32'hFFFF_FFFF, 12, a, t2);
    check("lat3_addr1", a, 32'h102);
    wait_req("lat3c", 32'hFFFF_FFFF, 12, a, t3);
    check("lat3_gap1", t2 - t1, 32'd5);
    check("lat3_gap2", t3 - t2, 32'd5);

    // Reset during WAIT, then a late response while in ISSUE.
    mem_auto = 1'b0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_lat = 1;
    wait_req("rst1", 32'hFFFF_FFFF, 4, a, t1);
    check("rst1_addr", a, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset("midwait_reset");
    @(posedge clk); #1;
    rst = 1'b0; inject = 1'b1; mem_auto = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(negedge clk);
    check("restart_req", {31'b0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    check("restart_vld", {31'b0, instr_valid}, 32'd0);
    stale_hits = 0;
    wait_vld("restart", 32'hFFFF_FFFF, 10, p, d);
    check("restart_pc", p, 32'h0);
    check("restart_instr", d, ~32'h0);
    check("restart_no_stale", stale_hits, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
